// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet layer sequencer.
package lenet_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 4;

  localparam int unsigned L_CONV1 = 0;
  localparam int unsigned L_CONV2 = 1;
  localparam int unsigned L_FC1   = 2;
  localparam int unsigned L_FC2   = 3;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LAUNCH,
    SEQ_WAIT,
    SEQ_NEXT,
    SEQ_DONE,
    SEQ_ERR
  } seq_state_e;

endpackage

// File: rtl/lenet_sat_counter.sv
// Clear/enable saturating up-counter with a combinational terminal-count compare.
module lenet_sat_counter #(
  parameter int unsigned W    = 20,
  parameter int unsigned TERM = 0
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term_c
);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign term_c = (count == W'(TERM));

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Top-level sequencer: launches each layer engine in turn, ping-pongs buffers,
// runs a batch of images, profiles layer latency and guards with a watchdog.
module lenet_layer_sequencer
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int unsigned BATCH_W     = 8,
  parameter int unsigned CYC_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [BATCH_W-1:0]            batch_num,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [NUM_LAYERS-1:0]         layer_start,
  output logic                          mem_sel,
  output logic                          busy,
  output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
  output logic [BATCH_W-1:0]            img_idx,
  output logic [CYC_W-1:0]              layer_cycles,
  output logic                          layer_cycles_valid,
  output logic                          frame_done,
  output logic                          all_done,
  output logic                          timeout_err
);

  localparam int unsigned LW   = $clog2(NUM_LAYERS);
  localparam int unsigned LAST = NUM_LAYERS - 1;

  seq_state_e             state, state_d;
  logic [LW-1:0]          cur_layer_d;
  logic [BATCH_W-1:0]     img_idx_d, batch_last, batch_last_d;
  logic                   mem_sel_d, busy_d, timeout_err_d;
  logic [NUM_LAYERS-1:0]  layer_start_d;
  logic [CYC_W-1:0]       layer_cycles_d;
  logic                   valid_d, frame_done_d, all_done_d;
  logic                   launch_c, done_c;

  logic [CYC_W-1:0]       cyc_cnt;
  logic                   wd_hit_c;

  // Expiry fires in the cycle the count would reach TIMEOUT_CYC.
  lenet_sat_counter #(
    .W    (CYC_W),
    .TERM (TIMEOUT_CYC - 1)
  ) u_cyc_cnt (
    .clk    (clk),
    .srstn  (srstn),
    .clr    (state == SEQ_LAUNCH),
    .en     (state == SEQ_WAIT),
    .count  (cyc_cnt),
    .term_c (wd_hit_c)
  );

  assign done_c = layer_done[cur_layer];

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state;
    cur_layer_d    = cur_layer;
    img_idx_d      = img_idx;
    batch_last_d   = batch_last;
    mem_sel_d      = mem_sel;
    timeout_err_d  = timeout_err;
    layer_cycles_d = layer_cycles;
    layer_start_d  = '0;
    valid_d        = 1'b0;
    frame_done_d   = 1'b0;
    all_done_d     = 1'b0;
    launch_c       = 1'b0;

    case (state)
      SEQ_IDLE, SEQ_ERR: begin
        if (start) begin
          batch_last_d  = (batch_num == '0) ? '0 : batch_num - BATCH_W'(1);
          img_idx_d     = '0;
          cur_layer_d   = '0;
          mem_sel_d     = 1'b0;
          timeout_err_d = 1'b0;
          launch_c      = 1'b1;
        end
      end
      SEQ_LAUNCH: state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        if (done_c) begin
          layer_cycles_d = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_W'(1);
          valid_d        = 1'b1;
          frame_done_d   = (cur_layer == LW'(LAST));
          state_d        = SEQ_NEXT;
        end else if (wd_hit_c) begin
          timeout_err_d = 1'b1;
          state_d       = SEQ_ERR;
        end
      end
      SEQ_NEXT: begin
        mem_sel_d = ~mem_sel;
        if (cur_layer != LW'(LAST)) begin
          cur_layer_d = cur_layer + LW'(1);
          launch_c    = 1'b1;
        end else if (img_idx == batch_last) begin
          all_done_d = 1'b1;
          state_d    = SEQ_DONE;
        end else begin
          img_idx_d   = img_idx + BATCH_W'(1);
          cur_layer_d = '0;
          mem_sel_d   = 1'b0;
          launch_c    = 1'b1;
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase

    if (launch_c) begin
      state_d       = SEQ_LAUNCH;
      layer_start_d = NUM_LAYERS'(1) << cur_layer_d;
    end

    // Abort overrides everything; indices and the sticky error simply hold.
    if (abort) begin
      state_d        = SEQ_IDLE;
      cur_layer_d    = cur_layer;
      img_idx_d      = img_idx;
      batch_last_d   = batch_last;
      timeout_err_d  = timeout_err;
      layer_cycles_d = layer_cycles;
      mem_sel_d      = 1'b0;
      layer_start_d  = '0;
      valid_d        = 1'b0;
      frame_done_d   = 1'b0;
      all_done_d     = 1'b0;
    end

    busy_d = (state_d == SEQ_LAUNCH) || (state_d == SEQ_WAIT) ||
             (state_d == SEQ_NEXT)   || (state_d == SEQ_DONE);
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state              <= SEQ_IDLE;
      cur_layer          <= '0;
      img_idx            <= '0;
      batch_last         <= '0;
      mem_sel            <= 1'b0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
      layer_start        <= '0;
      layer_cycles       <= '0;
      layer_cycles_valid <= 1'b0;
      frame_done         <= 1'b0;
      all_done           <= 1'b0;
    end else begin
      state              <= state_d;
      cur_layer          <= cur_layer_d;
      img_idx            <= img_idx_d;
      batch_last         <= batch_last_d;
      mem_sel            <= mem_sel_d;
      busy               <= busy_d;
      timeout_err        <= timeout_err_d;
      layer_start        <= layer_start_d;
      layer_cycles       <= layer_cycles_d;
      layer_cycles_valid <= valid_d;
      frame_done         <= frame_done_d;
      all_done           <= all_done_d;
    end
  end

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed self-checking bench for lenet_layer_sequencer with a delay-programmable engine model.
module tb_lenet_layer_sequencer;

  logic        clk = 1'b0;
  logic        srstn, start, abort;
  logic [7:0]  batch_num;
  logic [3:0]  layer_done, layer_start;
  logic        mem_sel, busy;
  logic [1:0]  cur_layer;
  logic [7:0]  img_idx;
  logic [19:0] layer_cycles;
  logic        layer_cycles_valid, frame_done, all_done, timeout_err;

  int          n_assert = 0;
  int          n_fail   = 0;

  int          eng_delay [4];
  int          rem [4];
  logic [3:0]  eng_en;
  logic [3:0]  eng_done = '0;
  logic [3:0]  spur_done;

  logic [3:0]  ls_log [$];
  logic        ms_log [$];
  logic [19:0] lc_log [$];
  logic [7:0]  fd_log [$];
  int          all_cnt = 0;

  always #5 clk = ~clk;

  assign layer_done = eng_done | spur_done;

  lenet_layer_sequencer #(
    .NUM_LAYERS  (4),
    .BATCH_W     (8),
    .CYC_W       (20),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk                (clk),
    .srstn              (srstn),
    .start              (start),
    .abort              (abort),
    .batch_num          (batch_num),
    .layer_done         (layer_done),
    .layer_start        (layer_start),
    .mem_sel            (mem_sel),
    .busy               (busy),
    .cur_layer          (cur_layer),
    .img_idx            (img_idx),
    .layer_cycles       (layer_cycles),
    .layer_cycles_valid (layer_cycles_valid),
    .frame_done         (frame_done),
    .all_done           (all_done),
    .timeout_err        (timeout_err)
  );

  // Engine model: done pulses eng_delay cycles after the observed start pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      eng_done[i] = 1'b0;
      if (!srstn) rem[i] = 0;
      else begin
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0 && eng_en[i]) eng_done[i] = 1'b1;
        end
        if (layer_start[i]) rem[i] = eng_delay[i];
      end
    end
  end

  always @(negedge clk) begin
    if (|layer_start) begin
      ls_log.push_back(layer_start);
      ms_log.push_back(mem_sel);
    end
    if (layer_cycles_valid) lc_log.push_back(layer_cycles);
    if (frame_done) fd_log.push_back(img_idx);
    if (all_done) all_cnt = all_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ls_log.delete(); ms_log.delete(); lc_log.delete(); fd_log.delete();
    all_cnt = 0;
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < 4; i++) eng_delay[i] = d;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk); start = 1'b1; batch_num = n;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy !== 1'b0 && k < max) begin @(negedge clk); k++; end
    if (k >= max) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ls(input string tag, input logic [3:0] pat, input int max);
    int k = 0;
    while (layer_start !== pat && k < max) begin @(negedge clk); k++; end
    if (k >= max) chk({tag, "_start_timeout"}, 32'(layer_start), 32'(pat));
  endtask

  task automatic check_one_image(input string tag, input logic [19:0] cyc);
    chk({tag, "_ls_n"}, 32'(ls_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ls_log.size(); i++) begin
      chk($sformatf("%s_ls%0d", tag, i), 32'(ls_log[i]), 32'(4'b0001 << i));
      chk($sformatf("%s_ms%0d", tag, i), 32'(ms_log[i]), 32'(i % 2));
    end
    chk({tag, "_lc_n"}, 32'(lc_log.size()), 32'd4);
    for (int i = 0; i < lc_log.size(); i++)
      chk($sformatf("%s_lc%0d", tag, i), 32'(lc_log[i]), 32'(cyc));
    chk({tag, "_fd_n"}, 32'(fd_log.size()), 32'd1);
    if (fd_log.size() > 0) chk({tag, "_fd_idx"}, 32'(fd_log[0]), 32'd0);
    chk({tag, "_all"}, 32'(all_cnt), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    srstn = 1'b0; start = 1'b0; abort = 1'b0; batch_num = '0;
    spur_done = '0; eng_en = 4'hF;
    set_delays(10);
    repeat (3) @(negedge clk);
    chk("rst_flags", {26'd0, busy, mem_sel, frame_done, all_done, layer_cycles_valid, timeout_err}, 32'd0);
    chk("rst_ls", 32'(layer_start), 32'd0);
    chk("rst_idx", {22'd0, cur_layer, img_idx}, 32'd0);
    chk("rst_lc", 32'(layer_cycles), 32'd0);
    srstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single image, 10-cycle engines
    clear_logs();
    @(negedge clk); start = 1'b1; batch_num = 8'd1;
    @(negedge clk); start = 1'b0;
    chk("t1_latency", 32'(layer_start), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", 300);
    check_one_image("t1", 20'd10);
    chk("t1_final_layer", 32'(cur_layer), 32'd3);
    chk("t1_terr", 32'(timeout_err), 32'd0);

    // 2: batch of three images
    clear_logs();
    pulse_start(8'd3);
    wait_idle("t2", 800);
    chk("t2_ls_n", 32'(ls_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < ls_log.size(); i++)
      chk($sformatf("t2_ls%0d", i), 32'(ls_log[i]), 32'(4'b0001 << (i % 4)));
    for (int i = 0; i < 12 && i < ms_log.size(); i += 4)
      chk($sformatf("t2_ms_img%0d", i / 4), 32'(ms_log[i]), 32'd0);
    chk("t2_fd_n", 32'(fd_log.size()), 32'd3);
    for (int i = 0; i < fd_log.size(); i++)
      chk($sformatf("t2_fd%0d", i), 32'(fd_log[i]), 32'(i));
    chk("t2_all", 32'(all_cnt), 32'd1);
    chk("t2_final_img", 32'(img_idx), 32'd2);

    // 3: layer 1 hangs, watchdog fires 50 cycles after WAIT entry
    clear_logs();
    eng_en = 4'b1101;
    pulse_start(8'd1);
    wait_ls("t3", 4'b0010, 100);
    repeat (50) @(negedge clk);
    chk("t3_terr_early", 32'(timeout_err), 32'd0);
    chk("t3_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t3_terr", 32'(timeout_err), 32'd1);
    chk("t3_busy_err", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("t3_err_hold", {30'd0, timeout_err, |layer_start}, 32'd2);
    eng_en = 4'hF;
    clear_logs();
    pulse_start(8'd1);
    chk("t3_restart_ls", 32'(layer_start), 32'h1);
    chk("t3_terr_clr", 32'(timeout_err), 32'd0);
    wait_idle("t3", 300);
    check_one_image("t3r", 20'd10);

    // 4: abort during layer 2 WAIT
    clear_logs();
    pulse_start(8'd1);
    wait_ls("t4", 4'b0100, 100);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_mem_sel", 32'(mem_sel), 32'd0);
    repeat (15) @(negedge clk);
    chk("t4_busy_late", 32'(busy), 32'd0);
    chk("t4_ls_n", 32'(ls_log.size()), 32'd3);
    chk("t4_lc_n", 32'(lc_log.size()), 32'd2);
    chk("t4_fd_n", 32'(fd_log.size()), 32'd0);
    chk("t4_all", 32'(all_cnt), 32'd0);
    @(negedge clk); start = 1'b1; abort = 1'b1; batch_num = 8'd1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("t4_abort_wins", {30'd0, busy, |layer_start}, 32'd0);

    // 5: spurious done on another layer, start while busy
    clear_logs();
    pulse_start(8'd1);
    @(negedge clk); spur_done = 4'b1000;
    @(negedge clk); spur_done = 4'b0000;
    @(negedge clk); start = 1'b1; batch_num = 8'd5;
    @(negedge clk); start = 1'b0;
    wait_idle("t5", 300);
    check_one_image("t5", 20'd10);
    chk("t5_img", 32'(img_idx), 32'd0);

    // 6: batch 0 treated as 1, done coincides with watchdog expiry
    clear_logs();
    set_delays(50);
    pulse_start(8'd0);
    wait_idle("t6", 600);
    check_one_image("t6", 20'd50);
    chk("t6_terr", 32'(timeout_err), 32'd0);
    set_delays(10);
    pulse_start(8'd2);
    wait_ls("t6", 4'b0010, 100);
    repeat (5) @(negedge clk);
    chk("t6_pre_rst", {29'd0, mem_sel, cur_layer}, 32'h5);
    #2 srstn = 1'b0;
    #1;
    chk("t6_rst_flags", {26'd0, busy, mem_sel, frame_done, all_done, layer_cycles_valid, timeout_err}, 32'd0);
    chk("t6_rst_idx", {22'd0, cur_layer, img_idx}, 32'd0);
    chk("t6_rst_lc", 32'(layer_cycles), 32'd0);
    @(negedge clk); srstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
